// File: rtl/seq_alu_pkg.sv
// seq_alu_pkg: op encodings and FSM state type shared by the seq_alu block.
package seq_alu_pkg;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SLL = 3'b011;
    localparam logic [2:0] OP_SRL = 3'b100;
    localparam logic [2:0] OP_MUL = 3'b101;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

endpackage

// File: rtl/seq_alu_mul.sv
// seq_alu_mul: iterative shift-add multiplier, one multiplier bit per cycle over WIDTH cycles.
// product presents the final low WIDTH bits combinationally in the cycle done is high.
module seq_alu_mul #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] product
);
    localparam int CW = $clog2(WIDTH + 1);

    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] acc, mcand, mplier;

    assign busy    = cnt != '0;
    assign done    = cnt == CW'(1);
    assign product = acc + (mplier[0] ? mcand : '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
        end else if (start) begin
            cnt    <= CW'(WIDTH);
            acc    <= '0;
            mcand  <= a;
            mplier <= b;
        end else if (busy) begin
            cnt    <= cnt - CW'(1);
            acc    <= product;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
        end
    end

endmodule

// File: rtl/seq_alu.sv
// seq_alu: handshaked sequential ALU (IDLE/BUSY/DONE) with registered result and flags.
// Define SEQ_ALU_MUL_EN to build the iterative MUL; otherwise op 101 returns a in one cycle.
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             carry,
    output logic             overflow
);
    localparam int SW = $clog2(WIDTH);

    state_t           state, state_nx;
    logic             accept, is_mul, mul_busy, mul_done, lt, alu_c, alu_v;
    logic [WIDTH-1:0] mul_p, alu_r;
    logic [WIDTH:0]   sum, diff;
    logic [SW-1:0]    sh;

`ifdef SEQ_ALU_MUL_EN
    assign is_mul = op == OP_MUL;
    seq_alu_mul #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (accept && is_mul),
        .a       (a),
        .b       (b),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_p)
    );
`else
    assign is_mul   = 1'b0;
    assign mul_busy = 1'b0;
    assign mul_done = 1'b0;
    assign mul_p    = '0;
`endif

    assign in_ready  = state == IDLE && !mul_busy;
    assign out_valid = state == DONE;
    assign accept    = in_valid && in_ready;

    assign sh   = b[SW-1:0];
    assign sum  = {1'b0, a} + {1'b0, b};
    assign diff = {1'b0, a} - {1'b0, b};
    assign lt   = $signed(a) < $signed(b);

    // diff[WIDTH] is the unsigned borrow, shared by SUB and SLT
    always_comb begin
        alu_r = op == OP_AND ? a & b :
                op == OP_OR  ? a | b :
                op == OP_ADD ? sum[WIDTH-1:0] :
                op == OP_SUB ? diff[WIDTH-1:0] :
                op == OP_SLT ? {{(WIDTH-1){1'b0}}, lt} :
                op == OP_SLL ? a << sh :
                op == OP_SRL ? a >> sh : a;
        alu_c = op == OP_ADD ? sum[WIDTH] :
                (op == OP_SUB || op == OP_SLT) ? diff[WIDTH] : 1'b0;
        alu_v = op == OP_ADD ? (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]) :
                op == OP_SUB ? (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]) : 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = accept ? (is_mul ? BUSY : DONE) : IDLE;
            BUSY:    state_nx = mul_done ? DONE : BUSY;
            DONE:    state_nx = out_ready ? IDLE : DONE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result   <= '0;
            zero     <= 1'b0;
            carry    <= 1'b0;
            overflow <= 1'b0;
        end else if (accept && !is_mul) begin
            result   <= alu_r;
            zero     <= alu_r == '0;
            carry    <= alu_c;
            overflow <= alu_v;
        end else if (state == BUSY && mul_done) begin
            result   <= mul_p;
            zero     <= mul_p == '0;
            carry    <= 1'b0;
            overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: scoreboard bench for seq_alu (WIDTH=32); expectations follow SEQ_ALU_MUL_EN.
module tb_seq_alu;
    import seq_alu_pkg::*;

`ifdef SEQ_ALU_MUL_EN
    localparam bit MUL_ON  = 1'b1;
    localparam int MUL_LAT = 33;
`else
    localparam bit MUL_ON  = 1'b0;
    localparam int MUL_LAT = 1;
`endif

    typedef struct {
        string       tag;
        logic [31:0] r;
        logic        z, c, v;
        int          lat;
    } exp_t;

    logic        clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic        in_ready, out_valid, zero, carry, overflow;
    logic [31:0] a = '0, b = '0, result;
    logic [2:0]  op = '0;
    int          checks = 0, errors = 0;
    exp_t        sb[$];

    seq_alu #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .carry     (carry),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) if (rst_n) check("excl", {63'b0, out_valid & in_ready}, 64'd0);

    function automatic exp_t mk(string tag, logic [31:0] r, logic c, logic v, int lat);
        exp_t e;
        e.tag = tag; e.r = r; e.z = r == 32'd0; e.c = c; e.v = v; e.lat = lat;
        return e;
    endfunction

    function automatic exp_t model(string tag, logic [31:0] x, logic [31:0] y, logic [2:0] o);
        longint s;
        logic [31:0] r;
        logic c, v;
        int lat;
        c = 1'b0; v = 1'b0; lat = 1; r = x;
        case (o)
            3'b000: r = x & y;
            3'b001: r = x | y;
            3'b010: begin
                s = longint'($signed(x)) + longint'($signed(y));
                r = x + y;
                c = ({32'b0, x} + {32'b0, y}) > 64'hFFFF_FFFF;
                v = s > 64'sd2147483647 || s < -64'sd2147483648;
            end
            3'b110: begin
                s = longint'($signed(x)) - longint'($signed(y));
                r = x - y;
                c = x < y;
                v = s > 64'sd2147483647 || s < -64'sd2147483648;
            end
            3'b111: begin
                r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
                c = x < y;
            end
            3'b011: r = x << y[4:0];
            3'b100: r = x >> y[4:0];
            default: begin
                r = MUL_ON ? x * y : x;
                lat = MUL_LAT;
            end
        endcase
        return mk(tag, r, c, v, lat);
    endfunction

    task automatic start_op(input logic [31:0] xa, input logic [31:0] xb, input logic [2:0] xop, input exp_t e);
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check({e.tag, ".rdy"}, {63'b0, in_ready}, 64'd1);
        a = xa; b = xb; op = xop; in_valid = 1'b1;
        sb.push_back(e);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic get_result();
        exp_t e;
        int   lat = 1;
        logic rdy = 1'b0;
        while (!out_valid && lat < 100) begin
            rdy |= in_ready;
            @(posedge clk);
            #1 lat++;
        end
        check("sb_nonempty", {63'b0, sb.size() != 0}, 64'd1);
        e = sb.pop_front();
        check({e.tag, ".valid"}, {63'b0, out_valid}, 64'd1);
        check({e.tag, ".result"}, {32'b0, result}, {32'b0, e.r});
        check({e.tag, ".zero"}, {63'b0, zero}, {63'b0, e.z});
        check({e.tag, ".carry"}, {63'b0, carry}, {63'b0, e.c});
        check({e.tag, ".ovf"}, {63'b0, overflow}, {63'b0, e.v});
        check({e.tag, ".lat"}, 64'(lat), 64'(e.lat));
        check({e.tag, ".busy_rdy"}, {63'b0, rdy}, 64'd0);
    endtask

    task automatic drain();
        @(negedge clk) out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        check("drain.idle", {62'b0, in_ready, out_valid}, 64'd2);
    endtask

    task automatic run(input logic [31:0] xa, input logic [31:0] xb, input logic [2:0] xop, input exp_t e);
        start_op(xa, xb, xop, e);
        get_result();
        drain();
    endtask

    initial begin
        logic [31:0] ra, rb;
        logic [2:0]  ro;
        logic        seen;
        repeat (2) @(posedge clk);
        #1;
        check("rst.outs", {result, 28'b0, out_valid, zero, carry, overflow}, 64'd0);
        check("rst.ready", {63'b0, in_ready}, 64'd1);
        rst_n = 1'b1;

        run(32'd224, 32'd282, OP_SUB, mk("sub", 32'hFFFF_FFC6, 1'b1, 1'b0, 1));
        run(32'd224, 32'd282, OP_SLT, mk("slt", 32'd1, 1'b1, 1'b0, 1));
        run(32'd3421, 32'd89, OP_AND, mk("and", 32'd89, 1'b0, 1'b0, 1));
        run(32'd3421, 32'd89, OP_OR, mk("or", 32'd3421, 1'b0, 1'b0, 1));
        run(32'd3421, 32'd89, OP_ADD, mk("add", 32'd3510, 1'b0, 1'b0, 1));
        run(32'hF0, 32'h0F, OP_AND, mk("and0", 32'd0, 1'b0, 1'b0, 1));
        run(32'h7FFF_FFFF, 32'd1, OP_ADD, mk("add_ovf", 32'h8000_0000, 1'b0, 1'b1, 1));
        run(32'hFFFF_FFFF, 32'd1, OP_ADD, mk("add_cy", 32'd0, 1'b1, 1'b0, 1));
        run(32'd224, 32'd89, OP_MUL, mk("mul", MUL_ON ? 32'd19936 : 32'd224, 1'b0, 1'b0, MUL_LAT));
        run(32'd0, 32'd12345, OP_MUL, mk("mul0", 32'd0, 1'b0, 1'b0, MUL_LAT));
        run(32'h1234, 32'd0, OP_SLL, mk("sll0", 32'h1234, 1'b0, 1'b0, 1));
        run(32'd1, 32'd31, OP_SLL, mk("sll31", 32'h8000_0000, 1'b0, 1'b0, 1));
        run(32'h8000_0000, 32'd36, OP_SRL, mk("srl4", 32'h0800_0000, 1'b0, 1'b0, 1));

        for (int i = 0; i < 10; i++) begin
            ra = $urandom; rb = $urandom; ro = 3'($urandom_range(0, 7));
            run(ra, rb, ro, model($sformatf("rnd%0d", i), ra, rb, ro));
        end

        start_op(32'd3, 32'd12, OP_OR, mk("hold", 32'd15, 1'b0, 1'b0, 1));
        get_result();
        @(negedge clk);
        a = 32'd5; b = 32'd6; op = OP_ADD; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("hold.valid", {62'b0, out_valid, in_ready}, 64'd2);
            check("hold.result", {32'b0, result}, 64'd15);
        end
        sb.push_back(mk("after_hold", 32'd11, 1'b0, 1'b0, 1));
        @(negedge clk) out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        check("release.idle", {62'b0, in_ready, out_valid}, 64'd2);
        @(posedge clk);
        #1 in_valid = 1'b0;
        get_result();
        drain();

        start_op(32'd224, 32'd89, OP_MUL, mk("aborted", 32'd0, 1'b0, 1'b0, 1));
        repeat (10) @(posedge clk);
        @(negedge clk) rst_n = 1'b0;
        #1;
        check("abort.outs", {result, 28'b0, out_valid, zero, carry, overflow}, 64'd0);
        check("abort.ready", {63'b0, in_ready}, 64'd1);
        sb.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1 seen |= out_valid;
        end
        check("abort.stale", {63'b0, seen}, 64'd0);
        run(32'd1, 32'd2, OP_ADD, mk("post_rst", 32'd3, 1'b0, 1'b0, 1));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
